auth_checker: RTL and testbench
===============================

AUTH_CHECKER -- requirements
Module: auth_checker

Interface
REQ-001 Parameter HIST_DEPTH, default 4: number of past hashes retained; legal values are 2..8.
REQ-002 Parameter MAX_FAILS, default 3: consecutive denials that trigger lockout.
REQ-003 Parameter LOCK_CYCLES, default 16: lockout duration in clocks.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port cur_hash, input, 16 bits: current hash from the hasher stage.
REQ-007 Port hash_update, input, 1 bit: cur_hash is new this cycle and is pushed into history.
REQ-008 Port pw, input, 16 bits: candidate password.
REQ-009 Port pw_valid, input, 1 bit: pw is offered.
REQ-010 Port pw_ready, output, 1 bit: block accepts pw this cycle.
REQ-011 Port grant, output, 1 bit: one-cycle pulse, password matched.
REQ-012 Port deny, output, 1 bit: one-cycle pulse, password rejected.
REQ-013 Port match_idx, output, 3 bits: history age of the matching entry (0 = newest); valid with grant.
REQ-014 Port locked, output, 1 bit: level, lockout active.

Function
REQ-015 FSM states are IDLE, CHECK, RESULT and LOCKED.
REQ-016 pw_ready shall be 1 only in IDLE; the handshake completes when pw_valid && pw_ready (cycle T); pw shall be latched at T; the FSM enters CHECK.
REQ-017 CHECK shall compare the latched pw against one history entry per cycle, age 0 first: entry k in cycle T+1+k.
REQ-018 Invalid (never-filled) history entries shall never match.
REQ-019 On the first match at age k, the FSM enters RESULT; grant=1 and match_idx=k in cycle T+k+2; fail count clears.
REQ-020 With no match after all HIST_DEPTH entries, deny=1 in cycle T+HIST_DEPTH+1; fail count increments, saturating at MAX_FAILS.
REQ-021 RESULT lasts exactly one cycle, then goes to IDLE, or to LOCKED if the fail count reached MAX_FAILS.
REQ-022 LOCKED shall hold locked=1 and pw_ready=0 for LOCK_CYCLES cycles, then clear the fail count and return to IDLE.
REQ-023 History is a shift register: hash_update pushes cur_hash at age 0, ages the other entries by one, drops the oldest entry and sets its valid bit.
REQ-024 hash_update outside CHECK shall apply immediately, including in IDLE, RESULT and LOCKED.
REQ-025 hash_update during CHECK:
- history is frozen;
- the latest cur_hash is held in a one-entry pending register;
- repeated updates overwrite the pending value;
- the pending push applies in the cycle after CHECK exits.
REQ-026 If a pending push and a new hash_update fall in the same cycle, the pending push applies first and the new push second, within that cycle's single update (net shift of two).
REQ-027 Comparison is full 16-bit equality; no partial matching.

Reset
REQ-028 While rst_n=0, the block shall enter IDLE.
REQ-029 While rst_n=0, all history valid bits, the pending flag, the fail count and the lock counter shall clear.
REQ-030 While rst_n=0, the outputs shall be pw_ready=1 (once IDLE), grant=0, deny=0, match_idx=0, locked=0.
REQ-031 Reset asserted mid-CHECK or mid-LOCKED shall abort the operation, emit no grant/deny pulse, and discard all history.

Configuration
REQ-032 Macro AUTH_LOCKOUT_EN.
- Defined: REQ-020 to REQ-022 lockout behaviour applies.
- Undefined: the LOCKED state, fail counter and lock counter are not built; locked is tied to 0; RESULT always returns to IDLE.

Structure
REQ-033 Package auth_pkg shall hold:
- the FSM state typedef;
- HASH_W=16;
- the default HIST_DEPTH, MAX_FAILS and LOCK_CYCLES constants.
REQ-034 Sub-module hash_history shall contain the shift register, valid bits, pending register and freeze input, and expose entry/valid by age index.

Verification
REQ-035 Test 1:
- Stimulus: push 0xA1B2, then 0x1234; offer pw=0x1234 at T.
- Response: grant at T+2, match_idx=0.
REQ-036 Test 2:
- Stimulus: push 0x0001, 0x0002, 0x0003, 0x0004; offer pw=0x0001.
- Response: grant at T+5, match_idx=3.
REQ-037 Test 3:
- Stimulus: history holds only two valid entries; offer pw=0x0000.
- Response: deny at T+5, with no false match on empty entries.
REQ-038 Test 4 (AUTH_LOCKOUT_EN):
- Stimulus: three wrong passwords.
- Response: after the third deny, locked=1 and pw_ready=0 for 16 cycles; a subsequent correct pw yields grant.
REQ-039 Test 5:
- Stimulus: hash_update pulses twice during CHECK, with 0x5555 then 0x6666.
- Response: only 0x6666 is pushed after CHECK; a later pw=0x5555 is denied.
REQ-040 Test 6:
- Stimulus: rst_n low in cycle T+2 of CHECK.
- Response: no grant/deny; pw_ready=1; all entries invalid; fail count 0.

Source files
------------

// File: rtl/auth_pkg.sv
// rtl/auth_pkg.sv - shared types and default constants for the password checker
// Contents: FSM state type, hash width, default history depth, fail limit and lockout length.
package auth_pkg;

    localparam int HASH_W          = 16;
    localparam int DEF_HIST_DEPTH  = 4;
    localparam int DEF_MAX_FAILS   = 3;
    localparam int DEF_LOCK_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        RESULT = 2'd2,
        LOCKED = 2'd3
    } auth_state_t;

endpackage

// File: rtl/hash_history.sv
// rtl/hash_history.sv - aged hash history shift register with one-entry pending push
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   hash_update, cur_hash push request and the hash to push
//   freeze                history held still; pushes are parked in the pending register
//   rd_idx                age to read (0 = newest)
//   rd_entry, rd_valid    stored hash at rd_idx and whether that slot was ever filled
module hash_history
    import auth_pkg::*;
#(
    parameter int DEPTH = DEF_HIST_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hash_update,
    input  logic [HASH_W-1:0] cur_hash,
    input  logic              freeze,
    input  logic [2:0]        rd_idx,
    output logic [HASH_W-1:0] rd_entry,
    output logic              rd_valid
);

    logic [HASH_W-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [HASH_W-1:0] pend_q;
    logic              pend_valid_q;

    // When unfrozen, a parked push and a fresh push can land together: the
    // parked value goes in first, so it ends up one slot older than cur_hash.
    logic              push_two;
    logic              push_one;
    logic [HASH_W-1:0] push_data;

    always_comb begin
        push_two  = !freeze && pend_valid_q && hash_update;
        push_one  = !freeze && (pend_valid_q ^ hash_update);
        push_data = pend_valid_q ? pend_q : cur_hash;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else if (freeze) begin
            if (hash_update) begin
                pend_q       <= cur_hash;
                pend_valid_q <= 1'b1;
            end
        end else begin
            pend_valid_q <= 1'b0;
            if (push_two) begin
                for (int i = DEPTH - 1; i >= 2; i--) begin
                    entry_q[i] <= entry_q[i-2];
                end
                entry_q[1] <= pend_q;
                entry_q[0] <= cur_hash;
                valid_q    <= (valid_q << 2) | DEPTH'(3);
            end else if (push_one) begin
                for (int i = DEPTH - 1; i >= 1; i--) begin
                    entry_q[i] <= entry_q[i-1];
                end
                entry_q[0] <= push_data;
                valid_q    <= (valid_q << 1) | DEPTH'(1);
            end
        end
    end

    always_comb begin
        rd_entry = '0;
        rd_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == 3'(i)) begin
                rd_entry = entry_q[i];
                rd_valid = valid_q[i];
            end
        end
    end

endmodule

// File: rtl/auth_checker.sv
// rtl/auth_checker.sv - checks a candidate password against recent hashes, with optional lockout
// Build option: AUTH_LOCKOUT_EN enables fail counting and the LOCKED state.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cur_hash, hash_update new hash from the hasher, pushed into history
//   pw, pw_valid, pw_ready candidate password handshake (ready only in IDLE)
//   grant, deny           one-cycle result pulses
//   match_idx             age of the matching entry, valid with grant
//   locked                lockout in progress
module auth_checker
    import auth_pkg::*;
#(
    parameter int HIST_DEPTH  = DEF_HIST_DEPTH,
    parameter int MAX_FAILS   = DEF_MAX_FAILS,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HASH_W-1:0] cur_hash,
    input  logic              hash_update,
    input  logic [HASH_W-1:0] pw,
    input  logic              pw_valid,
    output logic              pw_ready,
    output logic              grant,
    output logic              deny,
    output logic [2:0]        match_idx,
    output logic              locked
);

    localparam logic [2:0] LAST_IDX = 3'(HIST_DEPTH - 1);

    auth_state_t       state_q;
    logic [HASH_W-1:0] pw_q;
    logic [2:0]        idx_q;
    logic              grant_q;
    logic              deny_q;
    logic [2:0]        match_idx_q;
    logic [HASH_W-1:0] rd_entry;
    logic              rd_valid;
    logic              hit;

    hash_history #(
        .DEPTH (HIST_DEPTH)
    ) u_history (
        .clk         (clk),
        .rst_n       (rst_n),
        .hash_update (hash_update),
        .cur_hash    (cur_hash),
        .freeze      (state_q == CHECK),
        .rd_idx      (idx_q),
        .rd_entry    (rd_entry),
        .rd_valid    (rd_valid)
    );

    assign hit = rd_valid && (rd_entry == pw_q);

`ifdef AUTH_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    logic [FAIL_W-1:0] fail_cnt_q;
    logic [LOCK_W-1:0] lock_cnt_q;
`else
    // Lockout parameters have no effect when the lockout logic is not built.
    logic unused_lock_cfg;
    assign unused_lock_cfg = ^{32'(MAX_FAILS), 32'(LOCK_CYCLES)};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pw_q        <= '0;
            idx_q       <= '0;
            grant_q     <= 1'b0;
            deny_q      <= 1'b0;
            match_idx_q <= '0;
`ifdef AUTH_LOCKOUT_EN
            fail_cnt_q  <= '0;
            lock_cnt_q  <= '0;
`endif
        end else begin
            grant_q     <= 1'b0;
            deny_q      <= 1'b0;
            match_idx_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pw_valid) begin
                        pw_q    <= pw;
                        idx_q   <= '0;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    // One age per cycle; the first hit wins, so a hit on the
                    // last entry still grants rather than denies.
                    if (hit) begin
                        grant_q     <= 1'b1;
                        match_idx_q <= idx_q;
                        state_q     <= RESULT;
`ifdef AUTH_LOCKOUT_EN
                        fail_cnt_q  <= '0;
`endif
                    end else if (idx_q == LAST_IDX) begin
                        deny_q  <= 1'b1;
                        state_q <= RESULT;
`ifdef AUTH_LOCKOUT_EN
                        if (fail_cnt_q != FAIL_W'(MAX_FAILS)) begin
                            fail_cnt_q <= fail_cnt_q + 1'b1;
                        end
`endif
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                RESULT: begin
`ifdef AUTH_LOCKOUT_EN
                    if (fail_cnt_q == FAIL_W'(MAX_FAILS)) begin
                        lock_cnt_q <= LOCK_W'(LOCK_CYCLES - 1);
                        state_q    <= LOCKED;
                    end else begin
                        state_q <= IDLE;
                    end
`else
                    state_q <= IDLE;
`endif
                end
`ifdef AUTH_LOCKOUT_EN
                LOCKED: begin
                    if (lock_cnt_q == '0) begin
                        fail_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        lock_cnt_q <= lock_cnt_q - 1'b1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pw_ready  = (state_q == IDLE);
    assign grant     = grant_q;
    assign deny      = deny_q;
    assign match_idx = match_idx_q;
`ifdef AUTH_LOCKOUT_EN
    assign locked    = (state_q == LOCKED);
`else
    assign locked    = 1'b0;
`endif

endmodule

// File: tb/tb_auth_checker.sv
// tb/tb_auth_checker.sv - directed self-checking bench for auth_checker
module tb_auth_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cur_hash = '0;
    logic        hash_update = 1'b0;
    logic [15:0] pw = '0;
    logic        pw_valid = 1'b0;
    logic        pw_ready;
    logic        grant;
    logic        deny;
    logic [2:0]  match_idx;
    logic        locked;

    auth_checker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cur_hash    (cur_hash),
        .hash_update (hash_update),
        .pw          (pw),
        .pw_valid    (pw_valid),
        .pw_ready    (pw_ready),
        .grant       (grant),
        .deny        (deny),
        .match_idx   (match_idx),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_assert = 0;
    int          n_fail = 0;
    int          t_offer = 0;
    int          lat;
    logic        saw_grant;
    logic        saw_deny;
    logic [2:0]  got_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pw_valid = 1'b0;
        hash_update = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [15:0] h);
        cur_hash = h;
        hash_update = 1'b1;
        tick();
        hash_update = 1'b0;
    endtask

    // Waits for ready, completes the handshake in cycle T and returns in T+1.
    task automatic offer(input logic [15:0] p);
        int n = 0;
        while (!pw_ready && n < 40) begin
            tick();
            n++;
        end
        pw = p;
        pw_valid = 1'b1;
        t_offer = cyc;
        tick();
        pw_valid = 1'b0;
    endtask

    // Returns in the cycle carrying the grant/deny pulse; lat is measured from T.
    task automatic wait_result();
        int n = 0;
        while (!(grant || deny) && n < 40) begin
            tick();
            n++;
        end
        lat = (grant || deny) ? (cyc - t_offer) : -1;
        saw_grant = grant;
        saw_deny = deny;
        got_idx = match_idx;
    endtask

    task automatic expect_grant(input string tag, input int exp_lat, input logic [2:0] exp_idx);
        wait_result();
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_grant"}, saw_grant, 1'b1);
        check({tag, "_deny"}, saw_deny, 1'b0);
        check({tag, "_idx"}, got_idx, exp_idx);
    endtask

    task automatic expect_deny(input string tag);
        wait_result();
        check({tag, "_lat"}, lat, 5);
        check({tag, "_deny"}, saw_deny, 1'b1);
        check({tag, "_grant"}, saw_grant, 1'b0);
    endtask

    initial begin
        int bad;

        // Reset values
        tick();
        check("rst_pw_ready", pw_ready, 1'b1);
        check("rst_grant", grant, 1'b0);
        check("rst_deny", deny, 1'b0);
        check("rst_match_idx", match_idx, 3'd0);
        check("rst_locked", locked, 1'b0);
        rst_n = 1'b1;
        tick();

        // Test 1: newest entry matches
        push(16'hA1B2);
        push(16'h1234);
        offer(16'h1234);
        expect_grant("t1", 2, 3'd0);

        // Test 2: oldest entry matches
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        push(16'h0004);
        offer(16'h0001);
        expect_grant("t2", 5, 3'd3);

        // Test 3: empty slots hold zero data but must not match
        do_reset();
        push(16'h00AA);
        push(16'h00BB);
        offer(16'h0000);
        expect_deny("t3");

        // Test 4: three wrong passwords
        do_reset();
        push(16'h1111);
        offer(16'h2222);
        expect_deny("t4a");
        offer(16'h2222);
        expect_deny("t4b");
        offer(16'h2222);
        expect_deny("t4c");
`ifdef AUTH_LOCKOUT_EN
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!(locked === 1'b1 && pw_ready === 1'b0)) bad++;
        end
        check("t4_lock_hold", bad, 0);
        tick();
        check("t4_unlock_locked", locked, 1'b0);
        check("t4_unlock_ready", pw_ready, 1'b1);
`else
        tick();
        check("t4_nolock_locked", locked, 1'b0);
        check("t4_nolock_ready", pw_ready, 1'b1);
`endif
        offer(16'h1111);
        expect_grant("t4_after", 2, 3'd0);

        // Test 5: two updates during CHECK, only the last survives
        do_reset();
        push(16'h1111);
        offer(16'h9999);
        cur_hash = 16'h5555;
        hash_update = 1'b1;
        tick();
        hash_update = 1'b0;
        tick();
        cur_hash = 16'h6666;
        hash_update = 1'b1;
        tick();
        hash_update = 1'b0;
        expect_deny("t5_frozen");
        offer(16'h5555);
        expect_deny("t5_overwritten");
        offer(16'h6666);
        expect_grant("t5_pending", 2, 3'd0);
        offer(16'h1111);
        expect_grant("t5_aged", 3, 3'd1);

        // Test 7: pending push and live push in the same cycle
        do_reset();
        offer(16'hFFFF);
        cur_hash = 16'h7777;
        hash_update = 1'b1;
        tick();
        hash_update = 1'b0;
        expect_deny("t7_empty");
        cur_hash = 16'h8888;
        hash_update = 1'b1;
        tick();
        hash_update = 1'b0;
        offer(16'h7777);
        expect_grant("t7_pend_older", 3, 3'd1);
        offer(16'h8888);
        expect_grant("t7_live_newest", 2, 3'd0);

        // Test 6: reset in cycle T+2 of CHECK
        do_reset();
        push(16'h1234);
        offer(16'hAAAA);
        expect_deny("t6_pre_a");
        offer(16'hAAAA);
        expect_deny("t6_pre_b");
        offer(16'h4321);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", pw_ready, 1'b1);
        check("t6_rst_grant", grant, 1'b0);
        check("t6_rst_deny", deny, 1'b0);
        check("t6_rst_idx", match_idx, 3'd0);
        check("t6_rst_locked", locked, 1'b0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (grant !== 1'b0 || deny !== 1'b0) bad++;
        end
        check("t6_no_pulse", bad, 0);
        offer(16'h1234);
        expect_deny("t6_history_gone");
        tick();
        check("t6_fails_cleared", locked, 1'b0);
        check("t6_ready_after", pw_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
